// File: rtl/ram48_bus_slave.sv
// Byte-wide 48-entry register memory behind a req/ack bus.
// One transaction per request, completed by a single-cycle ack pulse.
module ram48_bus_slave #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              sample;
  logic              in_range;

  // An edge that is already acknowledging never samples, which caps throughput at one per two cycles.
  assign sample   = req & ~ack_q;
  assign in_range = ({1'b0, addr} < DEPTH_W);

  always_comb begin
    ack_d   = sample;
    err_d   = sample & ~in_range;
    rdata_d = rdata_q;
    if (sample && !wr) begin
      rdata_d = in_range ? mem_q[addr] : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (sample && wr && in_range) begin
        mem_q[addr] <= wdata;
      end
    end
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: tb/tb_ram48_bus_slave.sv
// Scoreboard bench for ram48_bus_slave: a reference memory model predicts each
// transaction's rdata/err, pushed at issue and compared when ack arrives.
module tb_ram48_bus_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       wr = 1'b0;
  logic [5:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       ack;
  logic [7:0] rdata;
  logic       err;

  typedef struct {
    bit         rd;
    logic [7:0] data;
    bit         err;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] model [48];
  logic [7:0] last_rd;
  int         checks = 0;
  int         errors = 0;

  ram48_bus_slave #(.DATA_W(8), .ADDR_W(6), .DEPTH(48)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .wr    (wr),
    .addr  (addr),
    .wdata (wdata),
    .ack   (ack),
    .rdata (rdata),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 48; i++) model[i] = 8'h00;
    last_rd = 8'h00;
  endtask

  function automatic exp_t predict(input bit w, input logic [5:0] a, input logic [7:0] d);
    exp_t e;
    e.rd  = !w;
    e.err = (a >= 6'd48);
    if (w) begin
      if (a < 6'd48) model[a] = d;
      e.data = last_rd;
    end else begin
      e.data  = (a < 6'd48) ? model[a] : 8'h00;
      last_rd = e.data;
    end
    return e;
  endfunction

  // Called at a negedge; returns at a negedge with req low and ack already low.
  task automatic txn(input string tag, input bit w, input logic [5:0] a, input logic [7:0] d);
    exp_t e;
    bit   got;
    sb.push_back(predict(w, a, d));
    req = 1'b1; wr = w; addr = a; wdata = d;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (ack) got = 1'b1;
    end
    e = sb.pop_front();
    if (got) begin
      check({tag, "_rdata"}, {24'h0, rdata}, {24'h0, e.data});
      check({tag, "_err"}, {31'h0, err}, {31'h0, e.err});
    end else begin
      check({tag, "_ack_timeout"}, 32'd0, 32'd1);
    end
    req = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check({tag, "_ack"}, {31'h0, ack}, 32'd0);
    check({tag, "_rdata"}, {24'h0, rdata}, 32'd0);
    check({tag, "_err"}, {31'h0, err}, 32'd0);
    @(negedge clk);
    check({tag, "_ack_held"}, {31'h0, ack}, 32'd0);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    logic [5:0] hs_addr [4];
    exp_t       e;
    int         n, last_cyc;

    model_clear();
    #3;
    check("rst_ack", {31'h0, ack}, 32'd0);
    check("rst_rdata", {24'h0, rdata}, 32'd0);
    check("rst_err", {31'h0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // descending write/read-back with random data
    for (int a = 47; a >= 0; a--) begin
      d = 8'($urandom_range(0, 255));
      txn("wr_desc", 1'b1, 6'(a), d);
      txn("rd_desc", 1'b0, 6'(a), 8'h00);
    end

    // corner patterns and neighbours
    txn("pat_wr0", 1'b1, 6'd0, 8'hA5);
    txn("pat_wr47", 1'b1, 6'd47, 8'h5A);
    txn("pat_rd0", 1'b0, 6'd0, 8'h00);
    txn("pat_rd47", 1'b0, 6'd47, 8'h00);
    txn("pat_rd1", 1'b0, 6'd1, 8'h00);
    txn("pat_rd46", 1'b0, 6'd46, 8'h00);

    // out of range
    txn("oor_wr48", 1'b1, 6'd48, 8'hFF);
    txn("oor_rd48", 1'b0, 6'd48, 8'h00);
    txn("oor_wr63", 1'b1, 6'd63, 8'h12);
    txn("oor_rd63", 1'b0, 6'd63, 8'h00);
    for (int a = 0; a < 48; a++) txn("oor_untouched", 1'b0, 6'(a), 8'h00);

    // reset clears memory
    for (int a = 0; a < 48; a++) txn("fill3c", 1'b1, 6'(a), 8'h3C);
    txn("fill_rd", 1'b0, 6'd20, 8'h00);
    pulse_reset("rst_pulse");
    for (int a = 0; a < 48; a++) txn("rst_clr", 1'b0, 6'(a), 8'h00);

    // handshake with req held high across 4 reads
    txn("hs_wr3", 1'b1, 6'd3, 8'h11);
    txn("hs_wr9", 1'b1, 6'd9, 8'h22);
    txn("hs_wr30", 1'b1, 6'd30, 8'h33);
    txn("hs_wr44", 1'b1, 6'd44, 8'h44);
    hs_addr[0] = 6'd3; hs_addr[1] = 6'd9; hs_addr[2] = 6'd30; hs_addr[3] = 6'd44;
    n = 0;
    last_cyc = 0;
    sb.push_back(predict(1'b0, hs_addr[0], 8'h00));
    req = 1'b1; wr = 1'b0; addr = hs_addr[0];
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      if (ack) begin
        e = sb.pop_front();
        check("hs_rdata", {24'h0, rdata}, {24'h0, e.data});
        if (n > 0) check("hs_ack_gap", 32'(cyc - last_cyc), 32'd2);
        last_cyc = cyc;
        n++;
        if (n < 4) begin
          addr = hs_addr[n];
          sb.push_back(predict(1'b0, hs_addr[n], 8'h00));
        end else begin
          req = 1'b0;
        end
      end
    end
    check("hs_ack_count", 32'(n), 32'd4);
    if (sb.size() != 0) sb.delete();

    // reset in the cycle after a read sample edge
    txn("mid_wr5", 1'b1, 6'd5, 8'h77);
    req = 1'b1; wr = 1'b0; addr = 6'd5;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_ack", {31'h0, ack}, 32'd0);
    @(negedge clk);
    req = 1'b0;
    check("mid_rst_ack2", {31'h0, ack}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_no_ack", {31'h0, ack}, 32'd0);
    end
    txn("mid_rd5", 1'b0, 6'd5, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
